irq_ctrl_perif: RTL

Memory-mapped interrupt controller for the 6502 system bus. It collects up to 8 external interrupt sources, synchronises them into the `clk_cpu` domain and latches them as edge- or level-triggered pending bits. It masks and prioritises them, and drives the CPU `IRQ` input. It occupies a 4-byte window decoded by the top level, e.g. `(AB & 16'hFFFC) == 16'h0030`, and follows the same `CS`/`CS_o` read convention as the other peripherals.

---
 rtl/irq_ctrl_perif_if.sv | 12 +
 rtl/irq_ctrl_perif.sv | 118 +++++++++++
 2 files changed

// File: rtl/irq_ctrl_perif_if.sv
// CPU-side register bus of the interrupt controller: address, strobes, selects and write data.
// DO is tri-stated, so it is a plain pin on the controller rather than part of this bundle.
interface irq_ctrl_perif_if;
  logic [1:0] AB;
  logic       WE;
  logic       CS;
  logic       CS_o;
  logic [7:0] DI;

  modport master (output AB, output WE, output CS, output CS_o, output DI);
  modport slave  (input AB, input WE, input CS, input CS_o, input DI);
endinterface

// File: rtl/irq_ctrl_perif.sv
// 6502-bus interrupt controller: synchronises up to 8 sources, latches edge/level pending bits,
// masks and prioritises them and drives a registered IRQ.
module irq_ctrl_perif #(
  parameter int NSRC = 4
) (
  input  logic                 clk_cpu,
  input  logic                 reset,
  irq_ctrl_perif_if.slave      bus,
  input  logic [NSRC-1:0]      src,
  output wire  [7:0]           DO,
  output logic                 irq
);

  // Register bits at and above NSRC never hold state.
  localparam logic [7:0] SRC_MASK = 8'((9'd1 << NSRC) - 9'd1);

  typedef enum logic [1:0] {
    REG_STATUS = 2'd0,
    REG_MASK   = 2'd1,
    REG_VECTOR = 2'd2,
    REG_MODE   = 2'd3
  } reg_sel_e;

  function automatic logic [7:0] vector_of(input logic [7:0] act);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      if (act[i]) begin
        v = {1'b1, 4'b0000, 3'(i)};
      end
    end
    return v;
  endfunction

  logic [7:0] s1_r, s2_r, s3_r;
  logic [7:0] pend_r, mask_r, mode_r, rdata_r;
  logic       irq_r;

  reg_sel_e   sel_s;
  logic       wr_s, rd_s;
  logic [7:0] active_s, vector_s, rise_s, w1c_s, mode_chg_s, pend_nxt_s, rdata_nxt_s;

  // Bus decode, pending-bit next state and read mux.
  always_comb begin
    sel_s    = reg_sel_e'(bus.AB);
    wr_s     = bus.CS & bus.WE;
    rd_s     = bus.CS & ~bus.WE;
    active_s = pend_r & mask_r;
    vector_s = vector_of(active_s);
    rise_s   = s2_r & ~s3_r;

    if (wr_s && (sel_s == REG_STATUS)) begin
      w1c_s = bus.DI & SRC_MASK;
    end else begin
      w1c_s = 8'h00;
    end

    if (wr_s && (sel_s == REG_MODE)) begin
      mode_chg_s = (bus.DI & SRC_MASK) ^ mode_r;
    end else begin
      mode_chg_s = 8'h00;
    end

    // Edge bits: a new edge beats a same-cycle W1C. Level bits track s2. A mode change wipes the bit.
    pend_nxt_s = ~mode_chg_s & SRC_MASK &
                 ((mode_r & (rise_s | (pend_r & ~w1c_s))) | (~mode_r & s2_r));

    case (sel_s)
      REG_STATUS: rdata_nxt_s = pend_r;
      REG_MASK:   rdata_nxt_s = mask_r;
      REG_VECTOR: rdata_nxt_s = vector_s;
      REG_MODE:   rdata_nxt_s = mode_r;
      default:    rdata_nxt_s = 8'h00;
    endcase
  end

  // Synchroniser, control registers, pending bits, read capture and IRQ output.
  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      s1_r    <= 8'h00;
      s2_r    <= 8'h00;
      s3_r    <= 8'h00;
      pend_r  <= 8'h00;
      mask_r  <= 8'h00;
      mode_r  <= 8'h00;
      rdata_r <= 8'h00;
      irq_r   <= 1'b0;
    end else begin
      s1_r   <= 8'(src) & SRC_MASK;
      s2_r   <= s1_r;
      s3_r   <= s2_r;
      pend_r <= pend_nxt_s;
      irq_r  <= |active_s;

      if (wr_s && (sel_s == REG_MASK)) begin
        mask_r <= bus.DI & SRC_MASK;
      end else begin
        mask_r <= mask_r;
      end

      if (wr_s && (sel_s == REG_MODE)) begin
        mode_r <= bus.DI & SRC_MASK;
      end else begin
        mode_r <= mode_r;
      end

      if (rd_s) begin
        rdata_r <= rdata_nxt_s;
      end else begin
        rdata_r <= rdata_r;
      end
    end
  end

  assign DO  = bus.CS_o ? rdata_r : 8'hzz;
  assign irq = irq_r;

endmodule
